// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: free-running h/v counters, frame counter,
// and sync/de/strobe decode delayed through a 1+PIPE_DELAY stage pipeline.
module vga_timing_gen #(
   parameter int unsigned H_DISPLAY  = 640,
   parameter int unsigned H_FRONT    = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BACK     = 48,
   parameter int unsigned V_DISPLAY  = 480,
   parameter int unsigned V_FRONT    = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BACK     = 33,
   parameter bit          H_POL      = 1'b0,
   parameter bit          V_POL      = 1'b0,
   parameter int unsigned PIPE_DELAY = 0,
   parameter int unsigned CNT_W      = 11
) (
   input  logic             video_clk,
   input  logic             reset_n,
   input  logic             enable,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic             line_start,
   output logic             frame_start,
   output logic             vblank_start,
   output logic [7:0]       frame_count
);

   localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
   localparam int unsigned VS_END   = VS_START + V_SYNC;
   localparam int unsigned NSTAGE   = PIPE_DELAY + 1;
   localparam int unsigned DEC_W    = 6;

   // Decode vector layout: {hsync, vsync, de, line_start, frame_start, vblank_start}
   localparam logic [DEC_W-1:0] DEC_IDLE = {~H_POL, ~V_POL, 4'b0000};

   logic [CNT_W-1:0] r_hcount;
   logic [CNT_W-1:0] r_vcount;
   logic [7:0]       r_frame_count;
   logic [DEC_W-1:0] r_pipe [NSTAGE];

   logic             w_h_last;
   logic             w_v_last;
   logic             w_h_zero;
   logic             w_hsync_act;
   logic             w_vsync_act;
   logic             w_de;
   logic [DEC_W-1:0] w_dec;

   assign w_h_last = (r_hcount == CNT_W'(H_TOTAL - 1));
   assign w_v_last = (r_vcount == CNT_W'(V_TOTAL - 1));
   assign w_h_zero = (r_hcount == '0);

   // Position and frame counters; everything holds while enable is low
   always_ff @(posedge video_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hcount      <= '0;
         r_vcount      <= '0;
         r_frame_count <= '0;
      end else if (enable) begin
         if (w_h_last) begin
            r_hcount <= '0;
            if (w_v_last) begin
               r_vcount      <= '0;
               r_frame_count <= r_frame_count + 8'd1;
            end else begin
               r_vcount <= r_vcount + CNT_W'(1);
            end
         end else begin
            r_hcount <= r_hcount + CNT_W'(1);
         end
      end
   end

   // Decode of the current counter position (vsync depends on vcount only)
   always_comb begin
      w_hsync_act = (r_hcount >= CNT_W'(HS_START)) && (r_hcount < CNT_W'(HS_END));
      w_vsync_act = (r_vcount >= CNT_W'(VS_START)) && (r_vcount < CNT_W'(VS_END));
      w_de        = (r_hcount < CNT_W'(H_DISPLAY)) && (r_vcount < CNT_W'(V_DISPLAY));
      w_dec       = {w_hsync_act ? H_POL : ~H_POL,
                     w_vsync_act ? V_POL : ~V_POL,
                     w_de,
                     w_h_zero,
                     w_h_zero && (r_vcount == '0),
                     w_h_zero && (r_vcount == CNT_W'(V_DISPLAY))};
   end

   // Output alignment pipeline; shifts regardless of enable
   always_ff @(posedge video_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(NSTAGE); i++) r_pipe[i] <= DEC_IDLE;
      end else begin
         r_pipe[0] <= w_dec;
         for (int i = 1; i < int'(NSTAGE); i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign hcount       = r_hcount;
   assign vcount       = r_vcount;
   assign frame_count  = r_frame_count;
   assign hsync        = r_pipe[NSTAGE-1][5];
   assign vsync        = r_pipe[NSTAGE-1][4];
   assign de           = r_pipe[NSTAGE-1][3];
   assign line_start   = r_pipe[NSTAGE-1][2];
   assign frame_start  = r_pipe[NSTAGE-1][1];
   assign vblank_start = r_pipe[NSTAGE-1][0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (small/pipelined/default geometry) checked
// every cycle against an arithmetic raster model driven by random enable.
module tb_vga_timing_gen;

   logic video_clk = 1'b0;
   logic reset_n;
   logic enable;

   always #5 video_clk = ~video_clk;

   logic [10:0] hc  [3];
   logic [10:0] vc  [3];
   logic [7:0]  fc  [3];
   logic        hsy [3];
   logic        vsy [3];
   logic        dex [3];
   logic        lst [3];
   logic        fst [3];
   logic        vbs [3];

   // DUT 0: small geometry, no extra delay, active-low syncs
   vga_timing_gen #(
      .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .H_POL(1'b0), .V_POL(1'b0), .PIPE_DELAY(0), .CNT_W(11)
   ) u_small (
      .video_clk(video_clk), .reset_n(reset_n), .enable(enable),
      .hcount(hc[0]), .vcount(vc[0]), .hsync(hsy[0]), .vsync(vsy[0]), .de(dex[0]),
      .line_start(lst[0]), .frame_start(fst[0]), .vblank_start(vbs[0]),
      .frame_count(fc[0])
   );

   // DUT 1: small geometry, 3 extra stages, active-high syncs
   vga_timing_gen #(
      .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .H_POL(1'b1), .V_POL(1'b1), .PIPE_DELAY(3), .CNT_W(11)
   ) u_pipe (
      .video_clk(video_clk), .reset_n(reset_n), .enable(enable),
      .hcount(hc[1]), .vcount(vc[1]), .hsync(hsy[1]), .vsync(vsy[1]), .de(dex[1]),
      .line_start(lst[1]), .frame_start(fst[1]), .vblank_start(vbs[1]),
      .frame_count(fc[1])
   );

   // DUT 2: default 640x480 geometry
   vga_timing_gen u_dflt (
      .video_clk(video_clk), .reset_n(reset_n), .enable(enable),
      .hcount(hc[2]), .vcount(vc[2]), .hsync(hsy[2]), .vsync(vsy[2]), .de(dex[2]),
      .line_start(lst[2]), .frame_start(fst[2]), .vblank_start(vbs[2]),
      .frame_count(fc[2])
   );

   int unsigned g_hd [3] = '{4, 4, 640};
   int unsigned g_hf [3] = '{1, 1, 16};
   int unsigned g_hs [3] = '{2, 2, 96};
   int unsigned g_hb [3] = '{1, 1, 48};
   int unsigned g_vd [3] = '{3, 3, 480};
   int unsigned g_vf [3] = '{1, 1, 10};
   int unsigned g_vs [3] = '{1, 1, 2};
   int unsigned g_vb [3] = '{1, 1, 33};
   bit          g_hp [3] = '{1'b0, 1'b1, 1'b0};
   bit          g_vp [3] = '{1'b0, 1'b1, 1'b0};
   int unsigned g_pd [3] = '{0, 3, 0};

   // Model state: enabled-cycle count since reset, and its value before each recent edge
   int unsigned t  [3];
   int unsigned th [3][16];
   int unsigned n_edge;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   function automatic int unsigned htot(int k);
      return g_hd[k] + g_hf[k] + g_hs[k] + g_hb[k];
   endfunction

   function automatic int unsigned vtot(int k);
      return g_vd[k] + g_vf[k] + g_vs[k] + g_vb[k];
   endfunction

   function automatic logic [5:0] idle_dec(int k);
      return {~g_hp[k], ~g_vp[k], 4'b0000};
   endfunction

   // Expected {hsync, vsync, de, line_start, frame_start, vblank_start} at position tt
   function automatic logic [5:0] exp_dec(int k, int unsigned tt);
      int unsigned h, v;
      logic hs_a, vs_a;
      h    = tt % htot(k);
      v    = (tt / htot(k)) % vtot(k);
      hs_a = (h >= g_hd[k] + g_hf[k]) && (h < g_hd[k] + g_hf[k] + g_hs[k]);
      vs_a = (v >= g_vd[k] + g_vf[k]) && (v < g_vd[k] + g_vf[k] + g_vs[k]);
      return {hs_a ? g_hp[k] : ~g_hp[k],
              vs_a ? g_vp[k] : ~g_vp[k],
              logic'((h < g_hd[k]) && (v < g_vd[k])),
              logic'(h == 0),
              logic'((h == 0) && (v == 0)),
              logic'((h == 0) && (v == g_vd[k]))};
   endfunction

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s dut%0d observed=%0d expected=%0d at %0t", tag, k, obs, exp, $time);
      end
   endtask

   task automatic chk_dec(input int k, input logic [5:0] e);
      chk("hsync",        k, 32'(hsy[k]), 32'(e[5]));
      chk("vsync",        k, 32'(vsy[k]), 32'(e[4]));
      chk("de",           k, 32'(dex[k]), 32'(e[3]));
      chk("line_start",   k, 32'(lst[k]), 32'(e[2]));
      chk("frame_start",  k, 32'(fst[k]), 32'(e[1]));
      chk("vblank_start", k, 32'(vbs[k]), 32'(e[0]));
   endtask

   task automatic check_all();
      for (int k = 0; k < 3; k++) begin
         chk("hcount",      k, 32'(hc[k]), t[k] % htot(k));
         chk("vcount",      k, 32'(vc[k]), (t[k] / htot(k)) % vtot(k));
         chk("frame_count", k, 32'(fc[k]), (t[k] / (htot(k) * vtot(k))) % 256);
         if (n_edge > g_pd[k]) chk_dec(k, exp_dec(k, th[k][g_pd[k]]));
         else                  chk_dec(k, idle_dec(k));
      end
   endtask

   task automatic check_reset();
      for (int k = 0; k < 3; k++) begin
         chk("rst_hcount",      k, 32'(hc[k]), 0);
         chk("rst_vcount",      k, 32'(vc[k]), 0);
         chk("rst_frame_count", k, 32'(fc[k]), 0);
         chk_dec(k, idle_dec(k));
      end
   endtask

   task automatic model_reset();
      n_edge = 0;
      for (int k = 0; k < 3; k++) begin
         t[k] = 0;
         for (int i = 0; i < 16; i++) th[k][i] = 0;
      end
   endtask

   // One clock: drive enable, advance the model across the edge, then check
   task automatic tick(input logic en);
      enable = en;
      @(posedge video_clk);
      n_edge++;
      for (int k = 0; k < 3; k++) begin
         for (int i = 15; i > 0; i--) th[k][i] = th[k][i-1];
         th[k][0] = t[k];
         if (en) t[k]++;
      end
      #1;
      check_all();
   endtask

   initial begin
      int guard;
      reset_n = 1'b0;
      enable  = 1'b0;
      model_reset();
      repeat (3) @(posedge video_clk);
      #1;
      check_reset();
      @(negedge video_clk);
      reset_n = 1'b1;

      // Straight run through the first frame and into the second
      repeat (60) tick(1'b1);

      // Park the small raster at (5,2) with enable low for 20 cycles
      guard = 0;
      while ((t[0] % 48) != 21 && guard < 100) begin
         tick(1'b1);
         guard++;
      end
      chk("reach_5_2", 0, 32'(t[0] % 48), 21);
      repeat (20) tick(1'b0);
      tick(1'b1);
      chk("resume_hcount", 0, 32'(hc[0]), 6);

      // Random enable until the small raster has wrapped frame_count past 255
      guard = 0;
      while (t[0] < 256 * 48 + 20 && guard < 20000) begin
         tick(logic'($urandom_range(0, 7) != 0));
         guard++;
      end
      chk("frame_wrap_budget", 0, 32'(t[0] >= 256 * 48 + 20), 1);

      // Asynchronous reset mid-line on the default raster at hcount 300
      guard = 0;
      while ((t[2] % 800) != 300 && guard < 900) begin
         tick(1'b1);
         guard++;
      end
      chk("reach_h300", 2, 32'(hc[2]), 300);
      #3;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_reset();
      repeat (2) @(posedge video_clk);
      #1;
      check_reset();
      @(negedge video_clk);
      reset_n = 1'b1;
      tick(1'b1);
      chk("first_frame_start", 0, 32'(fst[0]), 1);
      repeat (150) tick(1'b1);
      repeat (200) tick(logic'($urandom_range(0, 3) != 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
